// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-ramp generator.
//   breath_state_e : FSM state; its encoding is also the external phase code
//                    (IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4).
//   hold_cnt_w()   : width of the hold counter for a given HOLD_TICKS,
//                    clog2(HOLD_TICKS+1) with a minimum of one bit.
package breath_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } breath_state_e;

    function automatic int unsigned hold_cnt_w(input int unsigned hold_ticks);
        int unsigned w;
        w = $clog2(hold_ticks + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/breath_ramp_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every
// PRESCALE enabled clock cycles.
//   clk  : system clock
//   rst  : synchronous reset, active-high (count -> 0)
//   en   : count enable; low clears the count and suppresses tick
//   tick : high in the cycle where the count equals PRESCALE-1
module tick_gen #(
    parameter int unsigned PRESCALE = 262144
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        tick    = en && (count_q == LAST);
        count_d = count_q + 1'b1;
        if (!en || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/breath_ramp.sv
// breath_ramp: rise/hold/fall/hold brightness profile (or rise/hold/jump
// sawtooth) feeding a pwm value_input/en pair.
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   en        : run enable; low freezes state, value and hold counter
//   sawtooth  : sampled on HOLD_HI exit; 1 = jump to floor instead of falling
//   value_out : current duty value (registered)
//   value_wr  : one-cycle strobe when value_out has just been (re)loaded
//   phase     : current state code
module breath_ramp
    import breath_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE   = 262144,
    parameter int unsigned MIN_VAL    = 0,
    parameter int unsigned MAX_VAL    = 128,
    parameter int unsigned STEP       = 1,
    parameter int unsigned HOLD_TICKS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sawtooth,
    output logic [WIDTH-1:0]   value_out,
    output logic               value_wr,
    output logic [PHASE_W-1:0] phase
);

    localparam int unsigned HOLD_W = hold_cnt_w(HOLD_TICKS);
    localparam int unsigned XW     = WIDTH + 1;

    localparam logic [XW-1:0]     MIN_X  = XW'(MIN_VAL);
    localparam logic [XW-1:0]     MAX_X  = XW'(MAX_VAL);
    localparam logic [XW-1:0]     STEP_X = XW'(STEP);
    localparam logic [WIDTH-1:0]  MIN_V  = WIDTH'(MIN_VAL);
    localparam logic [HOLD_W-1:0] HOLD_X = HOLD_W'(HOLD_TICKS);

    if (MIN_VAL >= MAX_VAL) begin : g_chk_range
        $error("breath_ramp: MIN_VAL must be below MAX_VAL");
    end
    if (64'(MAX_VAL) >= (64'd1 << WIDTH)) begin : g_chk_max
        $error("breath_ramp: MAX_VAL must fit in WIDTH bits");
    end
    if (STEP < 1) begin : g_chk_step
        $error("breath_ramp: STEP must be at least 1");
    end
    // STEP is handled in WIDTH+1 bits, so it has to fit there.
    if (64'(STEP) >= (64'd1 << XW)) begin : g_chk_step_w
        $error("breath_ramp: STEP must fit in WIDTH+1 bits");
    end
    if (PRESCALE < 1) begin : g_chk_prescale
        $error("breath_ramp: PRESCALE must be at least 1");
    end

    breath_state_e     state_q, state_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic              wr_q, wr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              tick_en;
    logic              tick;
    logic [XW-1:0]     value_x;
    logic [XW-1:0]     up_val;
    logic [XW-1:0]     dn_val;
    logic [HOLD_W-1:0] hold_inc;
    logic              hold_done;

    // Prescaler idles in IDLE so the first ramp tick lands PRESCALE cycles
    // after the start write.
    assign tick_en = en && (state_q != ST_IDLE);

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .tick(tick)
    );

    always_comb begin
        value_x   = {1'b0, value_q};
        // Saturation tested on the headroom so the sum/difference cannot wrap.
        up_val    = (STEP_X >= MAX_X - value_x) ? MAX_X : value_x + STEP_X;
        dn_val    = (STEP_X >= value_x - MIN_X) ? MIN_X : value_x - STEP_X;
        hold_inc  = hold_q + 1'b1;
        hold_done = (hold_inc >= HOLD_X);

        state_d = state_q;
        value_d = value_q;
        wr_d    = 1'b0;
        hold_d  = hold_q;

        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    value_d = MIN_V;
                    wr_d    = 1'b1;
                    state_d = ST_RISE;
                end
                ST_RISE: begin
                    if (tick) begin
                        value_d = up_val[WIDTH-1:0];
                        wr_d    = 1'b1;
                        if (up_val == MAX_X) begin
                            state_d = ST_HOLD_HI;
                            hold_d  = '0;
                        end
                    end
                end
                ST_HOLD_HI: begin
                    if (tick) begin
                        hold_d = hold_inc;
                        if (hold_done) begin
                            hold_d = '0;
                            if (sawtooth) begin
                                value_d = MIN_V;
                                wr_d    = 1'b1;
                                state_d = ST_HOLD_LO;
                            end else begin
                                state_d = ST_FALL;
                            end
                        end
                    end
                end
                ST_FALL: begin
                    if (tick) begin
                        value_d = dn_val[WIDTH-1:0];
                        wr_d    = 1'b1;
                        if (dn_val == MIN_X) begin
                            state_d = ST_HOLD_LO;
                            hold_d  = '0;
                        end
                    end
                end
                ST_HOLD_LO: begin
                    if (tick) begin
                        hold_d = hold_inc;
                        if (hold_done) begin
                            hold_d  = '0;
                            state_d = ST_RISE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            value_q <= MIN_V;
            wr_q    <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            wr_q    <= wr_d;
            hold_q  <= hold_d;
        end
    end

    assign value_out = value_q;
    assign value_wr  = wr_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_breath_ramp.sv
module tb_breath_ramp;

    localparam int MP    = 4;
    localparam int MMIN  = 0;
    localparam int MMAX  = 8;
    localparam int MSTEP = 3;
    localparam int MHT   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, saw;
    logic [7:0] value;
    logic       wr;
    logic [2:0] ph;

    logic       rst_z, en_z, saw_z;
    logic [7:0] value_z;
    logic       wr_z;
    logic [2:0] ph_z;

    logic       rst_d, en_d, saw_d;
    logic [7:0] value_d;
    logic       wr_d;
    logic [2:0] ph_d;

    int n_tests = 0;
    int n_fail  = 0;

    breath_ramp #(
        .WIDTH(8), .PRESCALE(MP), .MIN_VAL(MMIN), .MAX_VAL(MMAX),
        .STEP(MSTEP), .HOLD_TICKS(MHT)
    ) u_main (
        .clk(clk), .rst(rst), .en(en), .sawtooth(saw),
        .value_out(value), .value_wr(wr), .phase(ph)
    );

    breath_ramp #(
        .WIDTH(8), .PRESCALE(MP), .MIN_VAL(MMIN), .MAX_VAL(MMAX),
        .STEP(MSTEP), .HOLD_TICKS(0)
    ) u_hold0 (
        .clk(clk), .rst(rst_z), .en(en_z), .sawtooth(saw_z),
        .value_out(value_z), .value_wr(wr_z), .phase(ph_z)
    );

    breath_ramp #(
        .WIDTH(8), .PRESCALE(1), .MIN_VAL(0), .MAX_VAL(128),
        .STEP(1), .HOLD_TICKS(16)
    ) u_dflt (
        .clk(clk), .rst(rst_d), .en(en_d), .sawtooth(saw_d),
        .value_out(value_d), .value_wr(wr_d), .phase(ph_d)
    );

    // Reference for u_main: phase number, value, hold and prescale counts
    // advanced with plain integer arithmetic from the ramp rules.
    int m_ph, m_val, m_hold, m_cnt;
    bit m_wr;

    always @(posedge clk) begin : ref_model
        bit tk;
        if (rst) begin
            m_ph = 0; m_val = MMIN; m_hold = 0; m_cnt = 0; m_wr = 0;
        end else begin
            m_wr = 0;
            if (!en) begin
                m_cnt = 0;
            end else if (m_ph == 0) begin
                m_val = MMIN; m_wr = 1; m_ph = 1; m_cnt = 0;
            end else begin
                tk    = (m_cnt == MP - 1);
                m_cnt = tk ? 0 : m_cnt + 1;
                if (tk) begin
                    if (m_ph == 1) begin
                        m_val = (m_val + MSTEP > MMAX) ? MMAX : m_val + MSTEP;
                        m_wr  = 1;
                        if (m_val == MMAX) begin m_ph = 2; m_hold = 0; end
                    end else if (m_ph == 3) begin
                        m_val = (m_val - MSTEP < MMIN) ? MMIN : m_val - MSTEP;
                        m_wr  = 1;
                        if (m_val == MMIN) begin m_ph = 4; m_hold = 0; end
                    end else begin
                        m_hold++;
                        if (m_hold >= MHT) begin
                            m_hold = 0;
                            if (m_ph == 4) m_ph = 1;
                            else if (saw) begin m_val = MMIN; m_wr = 1; m_ph = 4; end
                            else m_ph = 3;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; rst_z = 1; rst_d = 1;
        en = 0; en_z = 0; en_d = 0;
        saw = 0; saw_z = 0; saw_d = 0;
        step();
        n_tests++;
        if ({value, wr, ph} !== {8'd0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_in: got v=%0d wr=%0b ph=%0d expected 0/0/0", value, wr, ph);
        end
        step();
        rst = 0; rst_z = 0; rst_d = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n_tests++;
            if ({value, wr, ph} !== {8'd0, 1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d: got v=%0d wr=%0b ph=%0d expected 0/0/0", k, value, wr, ph);
            end
        end
    endtask

    task automatic test_rise();
        int wv[$];
        int wi[$];
        int exp_v[4] = '{0, 3, 6, 8};
        int exp_i[4] = '{0, 4, 8, 12};
        en = 1; saw = 0;
        for (int k = 0; k < 13; k++) begin
            step();
            n_tests++;
            if ({value, wr, ph} !== {8'(m_val), m_wr, 3'(m_ph)}) begin
                n_fail++;
                $display("FAIL rise_model k=%0d: got v=%0d wr=%0b ph=%0d expected v=%0d wr=%0b ph=%0d",
                         k, value, wr, ph, m_val, m_wr, m_ph);
            end
            if (wr) begin wv.push_back(int'(value)); wi.push_back(k); end
        end
        n_tests++;
        if (wv.size() != 4) begin
            n_fail++;
            $display("FAIL rise_count: got %0d writes expected 4", wv.size());
        end
        for (int i = 0; i < 4 && i < wv.size(); i++) begin
            n_tests++;
            if (wv[i] != exp_v[i] || wi[i] != exp_i[i]) begin
                n_fail++;
                $display("FAIL rise_write%0d: got v=%0d at %0d expected v=%0d at %0d",
                         i, wv[i], wi[i], exp_v[i], exp_i[i]);
            end
        end
        n_tests++;
        if (ph !== 3'd2) begin
            n_fail++;
            $display("FAIL rise_phase: got %0d expected 2", ph);
        end
    endtask

    task automatic test_fall();
        int wv[$];
        int wi[$];
        int exp_v[4] = '{5, 2, 0, 3};
        int exp_i[4] = '{11, 15, 19, 31};
        bit lo_seen = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            n_tests++;
            if ({value, wr, ph} !== {8'(m_val), m_wr, 3'(m_ph)}) begin
                n_fail++;
                $display("FAIL fall_model k=%0d: got v=%0d wr=%0b ph=%0d expected v=%0d wr=%0b ph=%0d",
                         k, value, wr, ph, m_val, m_wr, m_ph);
            end
            if (wr) begin wv.push_back(int'(value)); wi.push_back(k); end
            if (k == 19 && ph === 3'd4) lo_seen = 1;
        end
        n_tests++;
        if (wv.size() != 4) begin
            n_fail++;
            $display("FAIL fall_count: got %0d writes expected 4", wv.size());
        end
        for (int i = 0; i < 4 && i < wv.size(); i++) begin
            n_tests++;
            if (wv[i] != exp_v[i] || wi[i] != exp_i[i]) begin
                n_fail++;
                $display("FAIL fall_write%0d: got v=%0d at %0d expected v=%0d at %0d",
                         i, wv[i], wi[i], exp_v[i], exp_i[i]);
            end
        end
        n_tests++;
        if (!lo_seen) begin
            n_fail++;
            $display("FAIL fall_hold_lo: got phase!=4 after floor write expected 4");
        end
    endtask

    task automatic test_sawtooth();
        int wv[$];
        int wi[$];
        int exp_v[3] = '{6, 8, 0};
        int exp_i[3] = '{3, 7, 15};
        saw = 1;
        for (int k = 0; k < 16; k++) begin
            step();
            n_tests++;
            if ({value, wr, ph} !== {8'(m_val), m_wr, 3'(m_ph)}) begin
                n_fail++;
                $display("FAIL saw_model k=%0d: got v=%0d wr=%0b ph=%0d expected v=%0d wr=%0b ph=%0d",
                         k, value, wr, ph, m_val, m_wr, m_ph);
            end
            if (wr) begin wv.push_back(int'(value)); wi.push_back(k); end
        end
        saw = 0;
        n_tests++;
        if (wv.size() != 3) begin
            n_fail++;
            $display("FAIL saw_count: got %0d writes expected 3", wv.size());
        end
        for (int i = 0; i < 3 && i < wv.size(); i++) begin
            n_tests++;
            if (wv[i] != exp_v[i] || wi[i] != exp_i[i]) begin
                n_fail++;
                $display("FAIL saw_write%0d: got v=%0d at %0d expected v=%0d at %0d",
                         i, wv[i], wi[i], exp_v[i], exp_i[i]);
            end
        end
        n_tests++;
        if (ph !== 3'd4) begin
            n_fail++;
            $display("FAIL saw_phase: got %0d expected 4", ph);
        end
    endtask

    task automatic test_freeze();
        bit found = 0;
        int gap = -1;
        for (int k = 0; k < 64 && !found; k++) begin
            step();
            if (wr === 1'b1 && value === 8'd3 && ph === 3'd1) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL freeze_reach: got no write of 3 in RISE expected one within 64 cycles");
        end
        en = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_tests++;
            if ({value, wr, ph} !== {8'd3, 1'b0, 3'd1}) begin
                n_fail++;
                $display("FAIL freeze_hold k=%0d: got v=%0d wr=%0b ph=%0d expected 3/0/1", k, value, wr, ph);
            end
        end
        en = 1;
        for (int k = 1; k <= 20 && gap < 0; k++) begin
            step();
            if (wr === 1'b1) gap = k;
        end
        n_tests++;
        if (gap != 4 || value !== 8'd6) begin
            n_fail++;
            $display("FAIL freeze_resume: got write %0d at +%0d expected 6 at +4", value, gap);
        end
    endtask

    task automatic test_reset_mid_fall();
        bit found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (wr === 1'b1 && value === 8'd5 && ph === 3'd3) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL midfall_reach: got no write of 5 in FALL expected one within 200 cycles");
        end
        rst = 1;
        step();
        n_tests++;
        if ({value, wr, ph} !== {8'd0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL midfall_reset: got v=%0d wr=%0b ph=%0d expected 0/0/0", value, wr, ph);
        end
        rst = 0; en = 0;
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 1000; k++) begin
            rst = ($urandom_range(63) == 0);
            en  = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) saw = ~saw;
            step();
            n_tests++;
            if ({value, wr, ph} !== {8'(m_val), m_wr, 3'(m_ph)}) begin
                n_fail++;
                $display("FAIL random k=%0d: got v=%0d wr=%0b ph=%0d expected v=%0d wr=%0b ph=%0d",
                         k, value, wr, ph, m_val, m_wr, m_ph);
            end
        end
        rst = 0; en = 0; saw = 0;
    endtask

    task automatic test_hold0();
        bit found = 0;
        int gap = -1;
        en_z = 1;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (ph_z === 3'd2) found = 1;
        end
        n_tests++;
        if (!found || value_z !== 8'd8) begin
            n_fail++;
            $display("FAIL hold0_reach: got ph=%0d v=%0d expected 2/8", ph_z, value_z);
        end
        for (int k = 1; k <= 20 && gap < 0; k++) begin
            step();
            if (ph_z !== 3'd2) gap = k;
        end
        n_tests++;
        if (gap != 4 || ph_z !== 3'd3 || wr_z !== 1'b0) begin
            n_fail++;
            $display("FAIL hold0_exit: got ph=%0d wr=%0b at +%0d expected ph=3 wr=0 at +4", ph_z, wr_z, gap);
        end
        gap = -1;
        for (int k = 1; k <= 8 && gap < 0; k++) begin
            step();
            if (wr_z === 1'b1) gap = k;
        end
        n_tests++;
        if (gap != 4 || value_z !== 8'd5) begin
            n_fail++;
            $display("FAIL hold0_fall: got write %0d at +%0d expected 5 at +4", value_z, gap);
        end
        en_z = 0;
    endtask

    task automatic test_defaults();
        int writes = 0;
        int vmax = 0;
        int first_hi = -1;
        en_d = 1;
        step();
        n_tests++;
        if (wr_d !== 1'b1 || value_d !== 8'd0 || ph_d !== 3'd1) begin
            n_fail++;
            $display("FAIL dflt_start: got wr=%0b v=%0d ph=%0d expected 1/0/1", wr_d, value_d, ph_d);
        end
        for (int k = 1; k <= 288; k++) begin
            step();
            if (wr_d === 1'b1) writes++;
            if (int'(value_d) > vmax) vmax = int'(value_d);
            if (first_hi < 0 && ph_d === 3'd2) first_hi = k;
        end
        n_tests++;
        if (writes != 256) begin
            n_fail++;
            $display("FAIL dflt_writes: got %0d expected 256", writes);
        end
        n_tests++;
        if (writes + 1 != 257) begin
            n_fail++;
            $display("FAIL dflt_writes_incl_start: got %0d expected 257", writes + 1);
        end
        n_tests++;
        if (vmax != 128) begin
            n_fail++;
            $display("FAIL dflt_max: got %0d expected 128", vmax);
        end
        n_tests++;
        if (first_hi != 128) begin
            n_fail++;
            $display("FAIL dflt_ceiling_tick: got %0d expected 128", first_hi);
        end
        n_tests++;
        if (ph_d !== 3'd1 || value_d !== 8'd0) begin
            n_fail++;
            $display("FAIL dflt_period_end: got ph=%0d v=%0d expected 1/0", ph_d, value_d);
        end
        step();
        n_tests++;
        if (wr_d !== 1'b1 || value_d !== 8'd1) begin
            n_fail++;
            $display("FAIL dflt_next_period: got wr=%0b v=%0d expected 1/1", wr_d, value_d);
        end
        en_d = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_sawtooth();
        test_freeze();
        test_reset_mid_fall();
        test_random();
        test_hold0();
        test_defaults();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
